// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, IF/ID register, fetch counter
//
// Owns the program counter that addresses the (combinational) instruction
// memory and captures the returned word into the IF/ID pipeline register.
// Priority per rising edge: reset, jump, branch_taken, stall, normal advance.
//
// Ports:
//   CLK_SYS        system clock, rising edge
//   rst            asynchronous active-low reset
//   stall          hold PC, IF/ID and fetch_count
//   branch_taken   redirect to branch_target, inserting a bubble
//   branch_target  branch destination word address
//   jump           redirect to jump_target, inserting a bubble (beats branch)
//   jump_target    jump destination word address
//   instruction    instruction memory read data for the current pc
//   pc             current PC / instruction memory address
//   if_id_instr    registered instruction for decode (0 = NOP on bubble)
//   if_id_pc1      registered pc+1 of that instruction (0 on bubble)
//   if_id_valid    IF/ID holds a real instruction
//   fetch_count    saturating count of valid instructions loaded into IF/ID
module fetch_unit #(
  parameter int unsigned     PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             CLK_SYS,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             jump,
  input  logic [PC_W-1:0]  jump_target,
  input  logic [31:0]      instruction,
  output logic [PC_W-1:0]  pc,
  output logic [31:0]      if_id_instr,
  output logic [PC_W-1:0]  if_id_pc1,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [PC_W-1:0]  pc1_q, pc1_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_plus1;

  // Wraps modulo 2^PC_W: 1023 + 1 -> 0 for the default width.
  assign pc_plus1 = pc_q + PC_ONE;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (jump) begin
      // Redirects override stall; the word fetched this cycle is discarded.
      pc_d    = jump_target;
      instr_d = '0;
      pc1_d   = '0;
      valid_d = 1'b0;
    end else if (branch_taken) begin
      pc_d    = branch_target;
      instr_d = '0;
      pc1_d   = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_plus1;
      instr_d = instruction;
      pc1_d   = pc_plus1;
      valid_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int PC_W = 10;

  logic            CLK_SYS = 1'b0;
  logic            rst;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic [31:0]     instruction;
  logic [PC_W-1:0] pc;
  logic [31:0]     if_id_instr;
  logic [PC_W-1:0] if_id_pc1;
  logic            if_id_valid;
  logic [15:0]     fetch_count;

  logic [31:0]     instruction_s;
  logic [PC_W-1:0] pc_s;
  logic [31:0]     if_id_instr_s;
  logic [PC_W-1:0] if_id_pc1_s;
  logic            if_id_valid_s;
  logic [1:0]      fetch_count_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK_SYS = ~CLK_SYS;

  // Instruction memory model: word at address A is 32'h1000_0000 + A.
  assign instruction   = 32'h1000_0000 + {22'd0, pc};
  assign instruction_s = 32'h1000_0000 + {22'd0, pc_s};

  fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(16)) dut (
    .CLK_SYS(CLK_SYS), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instruction(instruction),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  // Narrow-counter copy so saturation is reached within the run.
  fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(2)) dut_sat (
    .CLK_SYS(CLK_SYS), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instruction(instruction_s),
    .pc(pc_s), .if_id_instr(if_id_instr_s), .if_id_pc1(if_id_pc1_s),
    .if_id_valid(if_id_valid_s), .fetch_count(fetch_count_s)
  );

  typedef struct {
    logic            stall;
    logic            br;
    logic [PC_W-1:0] bt;
    logic            jmp;
    logic [PC_W-1:0] jt;
    logic [PC_W-1:0] e_pc;
    logic [31:0]     e_instr;
    logic [PC_W-1:0] e_pc1;
    logic            e_valid;
    logic [15:0]     e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] word(input int a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic add_vec(input logic s, input logic b, input int bt_v,
                         input logic j, input int jt_v, input int epc,
                         input logic [31:0] ein, input int epc1,
                         input logic ev, input int ecnt);
    vec_t v;
    v.stall = s; v.br = b; v.bt = bt_v[PC_W-1:0];
    v.jmp = j; v.jt = jt_v[PC_W-1:0];
    v.e_pc = epc[PC_W-1:0]; v.e_instr = ein; v.e_pc1 = epc1[PC_W-1:0];
    v.e_valid = ev; v.e_cnt = ecnt[15:0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int epc, input logic [31:0] ein,
                         input int epc1, input logic ev, input int ecnt);
    int sat;
    sat = (ecnt > 3) ? 3 : ecnt;
    chk({tag, " pc"},    {22'd0, pc},          epc);
    chk({tag, " instr"}, if_id_instr,          ein);
    chk({tag, " pc1"},   {22'd0, if_id_pc1},   epc1);
    chk({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, ev});
    chk({tag, " cnt"},   {16'd0, fetch_count}, ecnt);
    chk({tag, " satcnt"}, {30'd0, fetch_count_s}, sat);
  endtask

  initial begin
    // Reset then run, stall, branch.
    add_vec(0,0,0,0,0,   1, word(0), 1, 1, 1);
    add_vec(0,0,0,0,0,   2, word(1), 2, 1, 2);
    add_vec(0,0,0,0,0,   3, word(2), 3, 1, 3);
    add_vec(0,0,0,0,0,   4, word(3), 4, 1, 4);
    add_vec(0,0,0,0,0,   5, word(4), 5, 1, 5);
    add_vec(1,0,0,0,0,   5, word(4), 5, 1, 5);
    add_vec(1,0,0,0,0,   5, word(4), 5, 1, 5);
    add_vec(0,0,0,0,0,   6, word(5), 6, 1, 6);
    add_vec(0,0,0,0,0,   7, word(6), 7, 1, 7);
    add_vec(0,0,0,0,0,   8, word(7), 8, 1, 8);
    add_vec(0,1,100,0,0, 100, 32'h0, 0, 0, 8);
    add_vec(0,0,0,0,0,   101, word(100), 101, 1, 9);
    // Simultaneous events: jump beats branch and stall; branch beats stall.
    add_vec(1,1,300,1,200, 200, 32'h0, 0, 0, 9);
    add_vec(1,1,40,0,0,    40, 32'h0, 0, 0, 9);
    add_vec(0,0,0,0,0,     41, word(40), 41, 1, 10);
    // Wrap from 1023.
    add_vec(0,0,0,1,1023,  1023, 32'h0, 0, 0, 10);
    add_vec(0,0,0,0,0,     0, word(1023), 0, 1, 11);
    add_vec(0,0,0,0,0,     1, word(0), 1, 1, 12);
    for (int k = 2; k <= 12; k++) add_vec(0,0,0,0,0, k, word(k-1), k, 1, 11 + k);

    // Reset held across an edge with a redirect pending must stay in reset.
    rst = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 10'd77;
    jump = 1'b1; jump_target = 10'd55;
    #9;
    chk_all("reset", 0, 32'h0, 0, 1'b0, 0);
    #1;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      jump = vecs[i].jmp; jump_target = vecs[i].jt;
      @(posedge CLK_SYS); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
              vecs[i].e_pc1, vecs[i].e_valid, vecs[i].e_cnt);
    end

    // Mid-run reset: asynchronous assert between edges at pc=12.
    #2;
    rst = 1'b0;
    #1;
    chk_all("midrst_async", 0, 32'h0, 0, 1'b0, 0);
    @(posedge CLK_SYS); #1;
    chk_all("midrst_hold", 0, 32'h0, 0, 1'b0, 0);
    @(negedge CLK_SYS);
    rst = 1'b1;
    @(posedge CLK_SYS); #1;
    chk_all("restart1", 1, word(0), 1, 1'b1, 1);
    @(posedge CLK_SYS); #1;
    chk_all("restart2", 2, word(1), 2, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter, drives the 10-bit word address into the instruction memory, and captures the returned 32-bit instruction into the IF/ID pipeline register for decode. It handles sequential advance, jump and branch redirects, pipeline stalls and flush bubbles, and keeps a saturating count of fetched instructions.

## Interface
- PC_W, 10, program-counter width; word address, one instruction per address
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of the fetched-instruction counter
- CLK_SYS  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted
- stall  input  1  hold PC and IF/ID contents this cycle
- branch_taken  input  1  redirect to branch_target
- branch_target  input  PC_W  branch destination word address
- jump  input  1  redirect to jump_target; has priority over branch_taken
- jump_target  input  PC_W  jump destination word address
- instruction  input  32  instruction memory read data for the current pc
- pc  output  PC_W  current PC, connected to the instruction memory address
- if_id_instr  output  32  registered instruction for decode
- if_id_pc1  output  PC_W  registered pc+1 of that instruction, for branch/link use
- if_id_valid  output  1  if_id_instr holds a real instruction (0 = bubble)
- fetch_count  output  CNT_W  number of instructions loaded valid into IF/ID, saturating

## Operation
- The instruction memory read is combinational. `instruction` reflects `pc` within the same cycle and is sampled by this block on the next rising edge of CLK_SYS.
- Per-edge priority, highest first: reset, jump, branch_taken, stall, normal advance.
- **Reset** (rst=0, asynchronous): pc=RESET_PC, if_id_instr=0, if_id_pc1=0, if_id_valid=0, fetch_count=0. All outputs hold these values while rst=0.
- **Normal advance** (no redirect, stall=0):
  - pc <= pc+1
  - if_id_instr <= instruction
  - if_id_pc1 <= pc+1
  - if_id_valid <= 1
  - fetch_count increments
- **Jump** (jump=1): pc <= jump_target. IF/ID is flushed: if_id_instr <= 0 (NOP), if_id_valid <= 0, if_id_pc1 <= 0. fetch_count is unchanged. branch_taken and stall are ignored.
- **Branch** (branch_taken=1, jump=0): same as jump, using branch_target.
- **Stall** (stall=1, no redirect): pc, IF/ID and fetch_count all hold.
- **Redirect during stall:** the redirect wins. The PC is updated and a bubble is inserted.
- **PC wrap-around:** pc+1 is computed modulo 2^PC_W. From 1023, the next pc is 0 and if_id_pc1 is 0.
- **Counter saturation:** fetch_count stops at 2^CNT_W-1 and does not wrap.
- **Reset mid-operation:** the asynchronous assert immediately forces reset values, regardless of stall or redirect. The first advance occurs on the first rising edge after rst returns to 1.

## Timing
- Latency: an instruction at address A is presented to decode (if_id_instr, if_id_valid=1) one cycle after pc=A, provided that cycle is not stalled or redirected.
- Redirect penalty: the edge that applies the redirect produces one bubble. The target instruction appears in IF/ID on the following edge.
- Stall is combinationally sampled at the rising edge. One stalled edge delays the stream by exactly one cycle, with no loss or duplication.
- All state changes occur on the rising edge of CLK_SYS, except the asynchronous reset assert.

## Test plan
- **Reset then run:** hold rst=0 for 10 ns, then release. Memory returns 32'h1000_0000+addr.
  - pc steps 0,1,2,3 on successive edges.
  - if_id_instr = 32'h1000_0000, 32'h1000_0001, … one cycle behind.
  - if_id_valid=1 from the first edge after release.
  - fetch_count=4 after 4 edges.
- **Stall:** at pc=5, assert stall for 2 edges.
  - pc stays 5.
  - if_id_instr stays the addr-4 word.
  - fetch_count is unchanged.
  - On release, pc=6 and if_id_instr is the addr-5 word.
- **Branch:** at pc=8, branch_taken=1 and branch_target=100.
  - Next edge: pc=100, if_id_valid=0, if_id_instr=0.
  - Following edge: if_id_instr is the addr-100 word, if_id_pc1=101.
- **Simultaneous events:** jump=1 (target 200), branch_taken=1 (target 300) and stall=1 together → pc=200 with a bubble. Then jump=0, stall=1, branch_taken=1 (target 40) → pc=40 with a bubble.
- **Wrap:** jump to 1023, then advance → pc=0 and if_id_pc1=0. The addr-1023 word enters IF/ID with valid=1.
- **Mid-run reset:** while running at pc=12, drop rst between clock edges.
  - pc=0, if_id_valid=0 and fetch_count=0 immediately, before the next edge.
  - After release, the sequence restarts at 0.
